// File: rtl/usb_pkt_pkg.sv
// rtl/usb_pkt_pkg.sv - USB packet constants, framer state encoding and CRC helpers
package usb_pkt_pkg;

   typedef enum logic [3:0] {
      PID_OUT   = 4'h1,
      PID_IN    = 4'h9,
      PID_SETUP = 4'hD,
      PID_DATA0 = 4'h3,
      PID_DATA1 = 4'hB,
      PID_ACK   = 4'h2,
      PID_NAK   = 4'hA,
      PID_STALL = 4'hE
   } pid_t;

   typedef enum logic [1:0] {
      KIND_HS   = 2'd0,
      KIND_DATA = 2'd1,
      KIND_TOK  = 2'd2,
      KIND_RSV  = 2'd3
   } pkt_kind_t;

   localparam logic [7:0]  SYNC_BYTE  = 8'h80;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY = 16'hA001;
   localparam logic [4:0]  CRC5_INIT  = 5'h1F;
   localparam logic [4:0]  CRC5_POLY  = 5'h14;

   // State names the byte currently presented on d (WAIT/DONE present none)
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_SYNC   = 4'd1;
   localparam logic [3:0] ST_PID    = 4'd2;
   localparam logic [3:0] ST_TOK1   = 4'd3;
   localparam logic [3:0] ST_TOK2   = 4'd4;
   localparam logic [3:0] ST_DATA   = 4'd5;
   localparam logic [3:0] ST_CRC_LO = 4'd6;
   localparam logic [3:0] ST_CRC_HI = 4'd7;
   localparam logic [3:0] ST_WAIT   = 4'd8;
   localparam logic [3:0] ST_DONE   = 4'd9;

   // One payload byte through the reflected CRC16, LSB first
   function automatic logic [15:0] crc16_byte(input logic [15:0] cur, input logic [7:0] b);
      logic [15:0] r;
      r = cur;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC16_POLY) : (r >> 1);
      return r;
   endfunction

   // Token CRC5 over {endp, addr} LSB first, returned already inverted
   function automatic logic [4:0] usb_crc5(input logic [10:0] v);
      logic [4:0] r;
      r = CRC5_INIT;
      for (int i = 0; i < 11; i++)
         r = (r[0] ^ v[i]) ? ((r >> 1) ^ CRC5_POLY) : (r >> 1);
      return ~r;
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - registered CRC16 accumulator, result valid one cycle after each byte
module usb_crc16
   import usb_pkt_pkg::*;
(
   input  logic        c,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  d,
   output logic [15:0] crc
);

   // Clear has priority so a new packet always starts from the init value
   always_ff @(posedge c) begin
      if (rst || clr)
         crc <= CRC16_INIT;
      else if (en)
         crc <= crc16_byte(crc, d);
   end

endmodule

// File: rtl/usb_tx_pkt.sv
// rtl/usb_tx_pkt.sv - USB packet framer feeding the SIE byte input; token support under USB_TX_PKT_TOKEN_EN
module usb_tx_pkt
   import usb_pkt_pkg::*;
#(
   parameter int MAX_LEN = 64,
   parameter int TIMEOUT = 12500
) (
   input  logic        c,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  kind,
   input  logic [3:0]  pid,
   input  logic [10:0] tok,
   input  logic        len0,
   input  logic [7:0]  pl_d,
   input  logic        pl_dv,
   input  logic        pl_last,
   output logic        pl_rdy,
   output logic [7:0]  d,
   output logic        dv,
   input  logic        sie_done,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(MAX_LEN + 2);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [3:0]    state;
   pkt_kind_t     kind_q;
   logic [3:0]    pid_q;
   logic          len0_q;
   logic          tail;       // last payload byte is on d, CRC low byte goes out next
   logic          err_flag;   // overflow seen in this packet
   logic          sie_q;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tcnt;
   logic [15:0]   crc;
   logic          acc;
   logic          ovf;
   logic          crc_clr;
   logic          crc_en;

`ifdef USB_TX_PKT_TOKEN_EN
   logic [10:0]   tok_q;
   logic [4:0]    crc5;
   assign crc5 = usb_crc5(tok_q);
`else
   logic          unused_tok;
   assign unused_tok = ^tok;
`endif

   assign acc     = pl_dv & pl_rdy;
   assign ovf     = acc & ~pl_last & (cnt == CW'(MAX_LEN));
   assign crc_clr = (state == ST_IDLE) & start;
   assign crc_en  = acc & ~ovf;

   usb_crc16 u_crc16 (
      .c   (c),
      .rst (rst),
      .clr (crc_clr),
      .en  (crc_en),
      .d   (pl_d),
      .crc (crc)
   );

   // Framing FSM: every output byte is registered on the edge that leaves the producing state
   always_ff @(posedge c) begin
      if (rst) begin
         state    <= ST_IDLE;
         kind_q   <= KIND_HS;
         pid_q    <= 4'h0;
         len0_q   <= 1'b0;
         tail     <= 1'b0;
         err_flag <= 1'b0;
         sie_q    <= 1'b0;
         cnt      <= '0;
         tcnt     <= '0;
         pl_rdy   <= 1'b0;
         d        <= 8'h00;
         dv       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef USB_TX_PKT_TOKEN_EN
         tok_q    <= '0;
`endif
      end else begin
         dv    <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         sie_q <= sie_done;
         if (state != ST_WAIT)
            tcnt <= '0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_SYNC;
                  busy     <= 1'b1;
                  d        <= SYNC_BYTE;
                  dv       <= 1'b1;
                  kind_q   <= pkt_kind_t'(kind);
                  pid_q    <= pid;
                  len0_q   <= len0;
                  cnt      <= '0;
                  tail     <= 1'b0;
                  err_flag <= 1'b0;
`ifdef USB_TX_PKT_TOKEN_EN
                  tok_q    <= tok;
`endif
               end
            end
            ST_SYNC: begin
               d     <= {~pid_q, pid_q};
               dv    <= 1'b1;
               state <= ST_PID;
               // Open the payload port while the PID is out so data follows without a gap
               if (kind_q == KIND_DATA && !len0_q)
                  pl_rdy <= 1'b1;
            end
            ST_PID: begin
               if (kind_q == KIND_DATA) begin
                  if (len0_q) begin
                     d     <= ~crc[7:0];
                     dv    <= 1'b1;
                     state <= ST_CRC_LO;
                  end else begin
                     state <= ST_DATA;
                  end
               end
`ifdef USB_TX_PKT_TOKEN_EN
               else if (kind_q == KIND_TOK) begin
                  d     <= tok_q[7:0];
                  dv    <= 1'b1;
                  state <= ST_TOK1;
               end
`endif
               else begin
                  state <= ST_WAIT;
               end
            end
`ifdef USB_TX_PKT_TOKEN_EN
            ST_TOK1: begin
               d     <= {crc5, tok_q[10:8]};
               dv    <= 1'b1;
               state <= ST_TOK2;
            end
            ST_TOK2: state <= ST_WAIT;
`endif
            ST_DATA: begin
               if (tail) begin
                  d     <= ~crc[7:0];
                  dv    <= 1'b1;
                  state <= ST_CRC_LO;
               end
            end
            ST_CRC_LO: begin
               // Overflowed packets carry the raw CRC so the receiver rejects them
               d     <= err_flag ? crc[15:8] : ~crc[15:8];
               dv    <= 1'b1;
               state <= ST_CRC_HI;
            end
            ST_CRC_HI: state <= ST_WAIT;
            ST_WAIT: begin
               if (sie_done && !sie_q) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  err   <= err_flag;
                  busy  <= 1'b0;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         // Payload acceptance overlaps the PID cycle and the DATA state
         if (acc) begin
            if (ovf) begin
               err_flag <= 1'b1;
               pl_rdy   <= 1'b0;
               d        <= crc[7:0];
               dv       <= 1'b1;
               state    <= ST_CRC_LO;
            end else begin
               d   <= pl_d;
               dv  <= 1'b1;
               cnt <= cnt + 1'b1;
               if (pl_last) begin
                  pl_rdy <= 1'b0;
                  tail   <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// tb/tb_usb_tx_pkt.sv - directed self-checking bench for usb_tx_pkt
module tb_usb_tx_pkt;

   localparam int MAXL = 64;
   localparam int TMO  = 20;

   logic        c = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  kind = 2'd0;
   logic [3:0]  pid = 4'h0;
   logic [10:0] tok = 11'h0;
   logic        len0 = 1'b0;
   logic [7:0]  pl_d = 8'h00;
   logic        pl_dv = 1'b0;
   logic        pl_last = 1'b0;
   logic        sie_done = 1'b0;
   logic        pl_rdy;
   logic [7:0]  d;
   logic        dv;
   logic        busy;
   logic        done;
   logic        err;

   int ncmp = 0;
   int nbad = 0;
   int cyc = 0;
   int t0 = 0;
   int done_cnt = 0;
   int done_t = 0;
   int db = 0;
   logic done_err = 1'b0;
   logic [7:0] cap_d[$];
   int         cap_t[$];
   logic [7:0] exp_d[$];
   logic [7:0] pay[0:127];

   usb_tx_pkt #(.MAX_LEN(MAXL), .TIMEOUT(TMO)) dut (
      .c(c), .rst(rst), .start(start), .kind(kind), .pid(pid), .tok(tok), .len0(len0),
      .pl_d(pl_d), .pl_dv(pl_dv), .pl_last(pl_last), .pl_rdy(pl_rdy),
      .d(d), .dv(dv), .sie_done(sie_done), .busy(busy), .done(done), .err(err)
   );

   always #5 c = ~c;

   always @(posedge c) cyc <= cyc + 1;

   always @(negedge c) begin
      if (dv) begin
         cap_d.push_back(d);
         cap_t.push_back(cyc);
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_t   <= cyc;
         done_err <= err;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d limit 20000", cyc);
      $fatal(1);
   end

   function automatic logic [15:0] crc16_of(input int n);
      logic [15:0] r = 16'hFFFF;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 8; j++)
            if (r[0] ^ pay[i][j]) r = (r >> 1) ^ 16'hA001;
            else r = r >> 1;
      return r;
   endfunction

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic clr_cap();
      cap_d.delete();
      cap_t.delete();
      exp_d.delete();
      db = done_cnt;
   endtask

   task automatic do_start(input logic [1:0] k, input logic [3:0] p, input logic [10:0] tk, input logic z);
      kind = k; pid = p; tok = tk; len0 = z;
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic send_payload(input int n, input bit last_flag, input int gap_at);
      int   i = 0;
      int   guard = 0;
      bit   gapped = 1'b0;
      logic rdy;
      while (i < n && guard < 400) begin
         if (i == gap_at && !gapped) begin
            pl_dv = 1'b0;
            gapped = 1'b1;
            tick();
         end
         pl_d = pay[i];
         pl_dv = 1'b1;
         pl_last = last_flag && (i == n - 1);
         rdy = pl_rdy;
         tick();
         if (rdy) i++;
         guard++;
      end
      pl_dv = 1'b0;
      pl_last = 1'b0;
      ncmp++;
      if (i != n) begin nbad++; $display("FAIL payload_accept: got %0d bytes want %0d", i, n); end
   endtask

   task automatic finish_pkt(output int s);
      repeat (4) tick();
      s = cyc;
      sie_done = 1'b1;
      tick();
      sie_done = 1'b0;
      for (int k = 0; k < 10 && done_cnt == db; k++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      ncmp++;
      if ({d, dv, pl_rdy, busy, done, err} !== 13'h0) begin
         nbad++; $display("FAIL reset_outputs: got %04h want 0000", {d, dv, pl_rdy, busy, done, err});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ack();
      int s;
      clr_cap();
      exp_d = {8'h80, 8'hD2};
      do_start(2'd0, 4'h2, 11'h0, 1'b0);
      ncmp++;
      if (busy !== 1'b1) begin nbad++; $display("FAIL ack_busy: got %b want 1", busy); end
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL ack_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL ack_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
      ncmp++;
      if (cap_t.size() == 0 || cap_t[0] != t0 + 1) begin nbad++; $display("FAIL ack_first_dv: got cycle %0d want %0d", cap_t.size() ? cap_t[0] : -1, t0 + 1); end
      ncmp++;
      if (done_cnt - db != 1 || done_t != s + 1) begin nbad++; $display("FAIL ack_done: got %0d pulses at %0d want 1 at %0d", done_cnt - db, done_t, s + 1); end
      ncmp++;
      if (done_err !== 1'b0) begin nbad++; $display("FAIL ack_err: got %b want 0", done_err); end
   endtask

   task automatic test_token();
      int s;
      clr_cap();
`ifdef USB_TX_PKT_TOKEN_EN
      exp_d = {8'h80, 8'h2D, 8'h00, 8'h10};
`else
      exp_d = {8'h80, 8'h2D};
`endif
      do_start(2'd2, 4'hD, 11'h000, 1'b0);
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL tok_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL tok_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
      ncmp++;
      if (done_cnt - db != 1 || done_err !== 1'b0) begin nbad++; $display("FAIL tok_done: got %0d pulses err %b want 1 err 0", done_cnt - db, done_err); end
   endtask

   task automatic test_reserved();
      int s;
      clr_cap();
      exp_d = {8'h80, 8'h5A};
      do_start(2'd3, 4'hA, 11'h7FF, 1'b0);
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL rsv_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL rsv_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
   endtask

   task automatic test_data_crc();
      int s;
      int gaps = 0;
      clr_cap();
      for (int i = 0; i < 9; i++) pay[i] = 8'(49 + i);
      exp_d = {8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
      do_start(2'd1, 4'h3, 11'h0, 1'b0);
      send_payload(9, 1'b1, -1);
      ncmp++;
      if (pl_rdy !== 1'b0) begin nbad++; $display("FAIL data_rdy_drop: got %b want 0", pl_rdy); end
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL data_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL data_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
      for (int i = 1; i < cap_t.size(); i++) if (cap_t[i] != cap_t[i-1] + 1) gaps++;
      ncmp++;
      if (gaps != 0 || cap_t.size() == 0 || cap_t[0] != t0 + 1) begin nbad++; $display("FAIL data_contig: got %0d gaps want 0 from cycle %0d", gaps, t0 + 1); end
      ncmp++;
      if (done_cnt - db != 1 || done_err !== 1'b0) begin nbad++; $display("FAIL data_done: got %0d pulses err %b want 1 err 0", done_cnt - db, done_err); end
   endtask

   task automatic test_data_gaps();
      int s;
      logic [15:0] r;
      clr_cap();
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
      r = ~crc16_of(3);
      exp_d = {8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, r[7:0], r[15:8]};
      do_start(2'd1, 4'hB, 11'h0, 1'b0);
      send_payload(3, 1'b1, 1);
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL gap_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL gap_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
   endtask

   task automatic test_len0();
      int s;
      clr_cap();
      exp_d = {8'h80, 8'h4B, 8'h00, 8'h00};
      do_start(2'd1, 4'hB, 11'h0, 1'b1);
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL len0_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL len0_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
      ncmp++;
      if (done_cnt - db != 1 || done_t != s + 1 || done_err !== 1'b0) begin nbad++; $display("FAIL len0_done: got %0d pulses at %0d err %b want 1 at %0d err 0", done_cnt - db, done_t, done_err, s + 1); end
   endtask

   task automatic test_overflow();
      int s;
      logic [15:0] r;
      clr_cap();
      for (int i = 0; i < MAXL + 1; i++) pay[i] = 8'(i * 3 + 1);
      r = crc16_of(MAXL);
      exp_d = {8'h80, 8'hC3};
      for (int i = 0; i < MAXL; i++) exp_d.push_back(pay[i]);
      exp_d.push_back(r[7:0]);
      exp_d.push_back(r[15:8]);
      do_start(2'd1, 4'h3, 11'h0, 1'b0);
      send_payload(MAXL + 1, 1'b0, -1);
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL ovf_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL ovf_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
      ncmp++;
      if (done_cnt - db != 1 || done_err !== 1'b1) begin nbad++; $display("FAIL ovf_done: got %0d pulses err %b want 1 err 1", done_cnt - db, done_err); end
   endtask

   task automatic test_timeout();
      clr_cap();
      do_start(2'd0, 4'h2, 11'h0, 1'b0);
      for (int k = 0; k < 100 && done_cnt == db; k++) tick();
      tick();
      ncmp++;
      if (done_cnt - db != 1 || done_t != t0 + 3 + TMO) begin nbad++; $display("FAIL tmo_time: got %0d pulses at %0d want 1 at %0d", done_cnt - db, done_t, t0 + 3 + TMO); end
      ncmp++;
      if (done_err !== 1'b1) begin nbad++; $display("FAIL tmo_err: got %b want 1", done_err); end
      ncmp++;
      if (busy !== 1'b0) begin nbad++; $display("FAIL tmo_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_data();
      int s;
      clr_cap();
      do_start(2'd1, 4'h3, 11'h0, 1'b0);
      pl_dv = 1'b1;
      pl_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pl_d = 8'(8'h10 + i);
         tick();
      end
      rst = 1'b1;
      tick();
      ncmp++;
      if ({d, dv, pl_rdy, busy, done, err} !== 13'h0) begin
         nbad++; $display("FAIL rst_mid_outputs: got %04h want 0000", {d, dv, pl_rdy, busy, done, err});
      end
      rst = 1'b0;
      pl_dv = 1'b0;
      sie_done = 1'b1;
      tick();
      sie_done = 1'b0;
      repeat (5) tick();
      ncmp++;
      if (done_cnt - db != 0) begin nbad++; $display("FAIL rst_late_sie: got %0d done pulses want 0", done_cnt - db); end
      clr_cap();
      exp_d = {8'h80, 8'hD2};
      do_start(2'd0, 4'h2, 11'h0, 1'b0);
      finish_pkt(s);
      ncmp++;
      if (cap_d.size() != exp_d.size()) begin nbad++; $display("FAIL rst_clean_count: got %0d want %0d", cap_d.size(), exp_d.size()); end
      foreach (exp_d[i]) if (i < cap_d.size()) begin
         ncmp++;
         if (cap_d[i] !== exp_d[i]) begin nbad++; $display("FAIL rst_clean_byte%0d: got %02h want %02h", i, cap_d[i], exp_d[i]); end
      end
      ncmp++;
      if (done_cnt - db != 1 || done_err !== 1'b0) begin nbad++; $display("FAIL rst_clean_done: got %0d pulses err %b want 1 err 0", done_cnt - db, done_err); end
   endtask

   initial begin
      test_reset();
      test_ack();
      test_token();
      test_reserved();
      test_data_crc();
      test_data_gaps();
      test_len0();
      test_overflow();
      test_timeout();
      test_reset_mid_data();
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
